// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with timer-interrupt trap entry and mret return.
// Redirects fetch through epc_taken/epc and squashes the one instruction behind each redirect.
//
// state | meaning
// RUN   | normal execution; an mret or a pending timer interrupt may redirect fetch
// FLUSH | instruction behind a redirect is discarded; no writes, mret or traps

module csr_trap_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_rf_wr,
    input  logic        csr_rf_rd,
    input  logic        mret,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] pc,
    input  logic        timer_irq,
    output logic [31:0] csr_rdata,
    output logic        epc_taken,
    output logic [31:0] epc
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH = 12'hB80;

    localparam logic [31:0] CAUSE_MTI    = 32'h8000_0007;
    localparam logic [31:0] VEC_OFS_MTI  = 32'h0000_001C;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic        mie_mtie_q, mie_mtie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic        sync1_q, sync2_q;

    logic        mip_mtip;
    logic        irq_take;
    logic        mret_take;
    logic        csr_we;
    logic [31:0] trap_base;

    assign mip_mtip  = sync2_q;
    assign mret_take = (state_q == RUN) & mret;
    assign irq_take  = (state_q == RUN) & mstatus_mie_q & mie_mtie_q & mip_mtip & ~mret;
    // A write colliding with a trap is dropped; the instruction replays after mret.
    assign csr_we    = (state_q == RUN) & csr_rf_wr & ~mret & ~irq_take;
    assign trap_base = {mtvec_q[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_mtie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mcycle_q       <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_mtie_q     <= mie_mtie_d;
            mtvec_q        <= mtvec_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mcycle_q       <= mcycle_d;
            sync1_q        <= timer_irq;
            sync2_q        <= sync1_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_mtie_d     = mie_mtie_q;
        mtvec_d        = mtvec_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mcycle_d       = mcycle_q + 64'd1;
        epc_taken      = 1'b0;
        epc            = '0;

        case (state_q)
            RUN: begin
                if (mret_take) begin
                    epc_taken      = 1'b1;
                    epc            = mepc_q;
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                    state_d        = FLUSH;
                end else if (irq_take) begin
                    epc_taken      = 1'b1;
                    epc            = (mtvec_q[1:0] == 2'b00) ? trap_base : trap_base + VEC_OFS_MTI;
                    mepc_d         = pc;
                    mcause_d       = CAUSE_MTI;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                    state_d        = FLUSH;
                end else if (csr_we) begin
                    case (csr_addr)
                        ADDR_MSTATUS: begin
                            mstatus_mie_d  = csr_wdata[3];
                            mstatus_mpie_d = csr_wdata[7];
                        end
                        ADDR_MIE:    mie_mtie_d = csr_wdata[7];
                        ADDR_MTVEC:  mtvec_d    = csr_wdata;
                        ADDR_MEPC:   mepc_d     = csr_wdata;
                        ADDR_MCAUSE: mcause_d   = csr_wdata;
                        // A written low word replaces the increment for that cycle.
                        ADDR_MCYCLE: mcycle_d   = {mcycle_q[63:32], csr_wdata};
                        default: ;
                    endcase
                end
            end
            FLUSH: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_rf_rd) begin
            case (csr_addr)
                ADDR_MSTATUS: csr_rdata = {24'h0, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
                ADDR_MIE:     csr_rdata = {24'h0, mie_mtie_q, 7'h00};
                ADDR_MTVEC:   csr_rdata = mtvec_q;
                ADDR_MEPC:    csr_rdata = mepc_q;
                ADDR_MCAUSE:  csr_rdata = mcause_q;
                ADDR_MIP:     csr_rdata = {24'h0, mip_mtip, 7'h00};
                ADDR_MCYCLE:  csr_rdata = mcycle_q[31:0];
                ADDR_MCYCLEH: csr_rdata = mcycle_q[63:32];
                default:      csr_rdata = '0;
            endcase
        end
    end

endmodule
